// File: rtl/i2s_rx_pkg.sv
// i2s_rx_pkg: shared state encoding, channel codes and sizing helper for
// the I2S sample receiver (i2s_sample_rx and its edge-detect front end).
package i2s_rx_pkg;

  // Receiver slot state: waiting for alignment, capturing data bits, or
  // skipping the unused tail of a wide codec slot.
  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    SHIFT = 2'd1,
    PAD   = 2'd2
  } rx_state_t;

  // lrck level that identifies each channel slot.
  localparam logic CH_LEFT  = 1'b0;
  localparam logic CH_RIGHT = 1'b1;

  // bit_cnt has to hold every value from 0 up to and including slot_width,
  // because the counter saturates at slot_width.
  function automatic int bit_cnt_width(input int slot_width);
    return $clog2(slot_width + 1);
  endfunction

endpackage

// File: rtl/i2s_edge_detect.sv
// i2s_edge_detect: registers the codec inputs once and flags lrck transitions.
// lrck_edge is high during the cycle in which the newly registered lrck
// differs from the value one cycle older.
module i2s_edge_detect
  import i2s_rx_pkg::*;
(
  input  logic sck,
  input  logic rst,
  input  logic lrck,
  input  logic sdata,
  output logic sd_q,
  output logic lrck_qq,
  output logic lrck_edge
);

  logic lrck_q;

  // Single input register stage plus one extra lrck delay for edge detection.
  always_ff @(posedge sck or posedge rst) begin
    if (rst) begin
      lrck_q  <= CH_LEFT;
      lrck_qq <= CH_LEFT;
      sd_q    <= 1'b0;
    end else begin
      lrck_q  <= lrck;
      lrck_qq <= lrck_q;
      sd_q    <= sdata;
    end
  end

  assign lrck_edge = lrck_q ^ lrck_qq;

endmodule

// File: rtl/i2s_sample_rx.sv
// i2s_sample_rx: deserialises an I2S stream into signed left/right samples,
// each announced by a one-cycle valid strobe, and flags malformed slots.
// Build option: define I2S_LJ_MODE_EN for left-justified framing (MSB in the
// lrck edge cycle); the default is Philips I2S with a one-bit delay.
module i2s_sample_rx
  import i2s_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int SLOT_WIDTH = 32
) (
  input  logic                  sck,
  input  logic                  rst,
  input  logic                  lrck,
  input  logic                  sdata,
  output logic [DATA_WIDTH-1:0] l_data,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic                  l_vld,
  output logic                  r_vld,
  output logic                  frame_err
);

  localparam int CW = bit_cnt_width(SLOT_WIDTH);
  localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  logic                  sd_q;
  logic                  lrck_qq;
  logic                  lrck_edge;
  rx_state_t             state;
  logic [CW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [DATA_WIDTH-1:0] cap_word;
  logic [DATA_WIDTH-1:0] start_word;
  logic [IW-1:0]         shift_idx;

  i2s_edge_detect u_edge (
    .sck       (sck),
    .rst       (rst),
    .lrck      (lrck),
    .sdata     (sdata),
    .sd_q      (sd_q),
    .lrck_qq   (lrck_qq),
    .lrck_edge (lrck_edge)
  );

  // Bits are written straight into their final MSB-first position, so a slot
  // that closes early is already left-aligned with zero-filled LSBs.
  // bit_cnt counts the non-edge cycles since the slot opened.
`ifdef I2S_LJ_MODE_EN
  // The MSB arrives in the edge cycle itself and seeds the next slot, so
  // the following bits start one position below the MSB.
  localparam int FIRST_SHIFT_POS = DATA_WIDTH - 2;

  // Closing word is already complete; the edge-cycle bit opens the new slot.
  always_comb begin
    cap_word                 = shift_reg;
    start_word               = '0;
    start_word[DATA_WIDTH-1] = sd_q;
  end
`else
  // The edge-cycle bit is still the LSB position of the closing slot, and
  // the new slot's MSB arrives on the cycle after the edge.
  localparam int FIRST_SHIFT_POS = DATA_WIDTH - 1;

  // Fold the edge-cycle bit into the closing word if data bits are pending.
  always_comb begin
    cap_word   = shift_reg;
    start_word = '0;
    if (state == SHIFT) begin
      cap_word[shift_idx] = sd_q;
    end
  end
`endif

  assign shift_idx = IW'(FIRST_SHIFT_POS) - IW'(bit_cnt);

  // Slot FSM: closes slots on lrck edges, captures data, handles timeouts.
  always_ff @(posedge sck or posedge rst) begin
    if (rst) begin
      state     <= SYNC;
      bit_cnt   <= '0;
      shift_reg <= '0;
      l_data    <= '0;
      r_data    <= '0;
      l_vld     <= 1'b0;
      r_vld     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      l_vld     <= 1'b0;
      r_vld     <= 1'b0;
      frame_err <= 1'b0;
      if (lrck_edge) begin
        if (state != SYNC) begin
          unique case (lrck_qq)
            CH_LEFT: begin
              l_data <= cap_word;
              l_vld  <= 1'b1;
            end
            CH_RIGHT: begin
              r_data <= cap_word;
              r_vld  <= 1'b1;
            end
          endcase
          frame_err <= (bit_cnt < CW'(DATA_WIDTH - 1));
        end
        state     <= SHIFT;
        bit_cnt   <= '0;
        shift_reg <= start_word;
      end else begin
        unique case (state)
          SYNC: begin
          end
          SHIFT, PAD: begin
            if (bit_cnt == CW'(SLOT_WIDTH - 1)) begin
              frame_err <= 1'b1;
              state     <= SYNC;
              bit_cnt   <= CW'(SLOT_WIDTH);
            end else begin
              bit_cnt <= bit_cnt + CW'(1);
              if (state == SHIFT) begin
                shift_reg[shift_idx] <= sd_q;
                if (bit_cnt == CW'(FIRST_SHIFT_POS)) begin
                  state <= PAD;
                end
              end
            end
          end
          default: state <= SYNC;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2s_sample_rx.sv
// tb_i2s_sample_rx: randomized and directed I2S streams checked against a
// reference model that derives expected strobes and samples directly from
// the raw lrck/sdata sequence (slot boundaries, slot lengths, data offset).
// Honours I2S_LJ_MODE_EN to match the build of the design.
module tb_i2s_sample_rx;

  localparam int DW = 16;
  localparam int SW = 32;
`ifdef I2S_LJ_MODE_EN
  localparam int FMT_DLY = 0;
`else
  localparam int FMT_DLY = 1;
`endif

  logic          sck = 1'b0;
  logic          rst;
  logic          lrck;
  logic          sdata;
  logic [DW-1:0] l_data;
  logic [DW-1:0] r_data;
  logic          l_vld;
  logic          r_vld;
  logic          frame_err;

  int checks = 0;
  int errors = 0;
  int err_pulses;

  bit            seg_lr[$];
  bit            seg_sd[$];
  bit            exp_lv[];
  bit            exp_rv[];
  bit            exp_err[];
  logic [DW-1:0] exp_ld[];
  logic [DW-1:0] exp_rd[];

  i2s_sample_rx #(.DATA_WIDTH(DW), .SLOT_WIDTH(SW)) dut (
    .sck       (sck),
    .rst       (rst),
    .lrck      (lrck),
    .sdata     (sdata),
    .l_data    (l_data),
    .r_data    (r_data),
    .l_vld     (l_vld),
    .r_vld     (r_vld),
    .frame_err (frame_err)
  );

  always #5 sck = ~sck;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Stream builder: seg_sd always holds one more entry than seg_lr so a
  // delayed-format slot can place its last bit in the following slot.
  task automatic newSegment();
    seg_lr.delete();
    seg_sd.delete();
    seg_sd.push_back(1'($urandom));
  endtask

  task automatic addIdle(input bit ch, input int n);
    for (int k = 0; k < n; k++) begin
      seg_lr.push_back(ch);
      seg_sd.push_back(1'($urandom));
    end
  endtask

  task automatic addSlot(input bit ch, input int len, input logic [DW-1:0] word, input int dly, input bit pad_ones);
    int base;
    base = seg_lr.size();
    for (int k = 0; k < len; k++) begin
      seg_lr.push_back(ch);
      seg_sd.push_back(1'($urandom));
    end
    for (int k = 0; k < len; k++) begin
      if (k < DW) seg_sd[base + dly + k] = word[DW-1-k];
      else        seg_sd[base + dly + k] = pad_ones ? 1'b1 : 1'($urandom);
    end
  endtask

  // Reference model: every lrck change (relative to the reset level 0) opens
  // a slot; the slot closes at the next change. A slot longer than SW cycles
  // raises frame_err SW+1 cycles after it opened and yields no sample;
  // otherwise its first min(len,DW) stream bits, starting FMT_DLY cycles
  // after the change, form a left-aligned word presented one cycle after
  // the closing change, with frame_err when len < DW.
  task automatic computeExpected();
    int            n;
    int            edges[$];
    bit            prev;
    int            e0;
    int            nxt;
    int            len;
    bit            has_next;
    logic [DW-1:0] w;
    logic [DW-1:0] cur_l;
    logic [DW-1:0] cur_r;
    n = seg_lr.size();
    exp_lv  = new[n];
    exp_rv  = new[n];
    exp_err = new[n];
    exp_ld  = new[n];
    exp_rd  = new[n];
    for (int i = 0; i < n; i++) begin
      exp_lv[i] = 0; exp_rv[i] = 0; exp_err[i] = 0; exp_ld[i] = '0; exp_rd[i] = '0;
    end
    prev = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (seg_lr[i] != prev) edges.push_back(i);
      prev = seg_lr[i];
    end
    for (int j = 0; j < edges.size(); j++) begin
      e0       = edges[j];
      has_next = (j + 1 < edges.size());
      nxt      = has_next ? edges[j+1] : n;
      len      = nxt - e0;
      if (len > SW) begin
        if (e0 + SW + 1 < n) exp_err[e0 + SW + 1] = 1;
      end else if (has_next && (nxt + 1 < n)) begin
        w = '0;
        for (int k = 0; k < DW && k < len; k++) w[DW-1-k] = seg_sd[e0 + FMT_DLY + k];
        if (seg_lr[e0] == 1'b0) begin
          exp_lv[nxt+1] = 1; exp_ld[nxt+1] = w;
        end else begin
          exp_rv[nxt+1] = 1; exp_rd[nxt+1] = w;
        end
        if (len < DW) exp_err[nxt+1] = 1;
      end
    end
    cur_l = '0;
    cur_r = '0;
    for (int p = 0; p < n; p++) begin
      if (exp_lv[p]) cur_l = exp_ld[p];
      if (exp_rv[p]) cur_r = exp_rd[p];
      exp_ld[p] = cur_l;
      exp_rd[p] = cur_r;
    end
  endtask

  // Entered on a negedge; drives the first 'cut' stream entries one per
  // cycle and checks every output after each rising edge.
  task automatic applyStimulus(input int cut);
    int n;
    computeExpected();
    n = (cut < seg_lr.size()) ? cut : seg_lr.size();
    err_pulses = 0;
    for (int t = 0; t <= n; t++) begin
      if (t > 0) begin
        if (frame_err === 1'b1) err_pulses++;
        checkOutput($sformatf("l_vld[%0d]", t-1), 32'(l_vld), 32'(exp_lv[t-1]));
        checkOutput($sformatf("r_vld[%0d]", t-1), 32'(r_vld), 32'(exp_rv[t-1]));
        checkOutput($sformatf("frame_err[%0d]", t-1), 32'(frame_err), 32'(exp_err[t-1]));
        checkOutput($sformatf("l_data[%0d]", t-1), 32'(l_data), 32'(exp_ld[t-1]));
        checkOutput($sformatf("r_data[%0d]", t-1), 32'(r_data), 32'(exp_rd[t-1]));
        checkOutput($sformatf("vld_excl[%0d]", t-1), 32'(l_vld & r_vld), 32'd0);
      end
      if (t < n) begin
        lrck  = seg_lr[t];
        sdata = seg_sd[t];
        @(negedge sck);
      end
    end
  endtask

  task automatic checkZero(input string pfx);
    checkOutput({pfx, "_l_data"}, 32'(l_data), 32'd0);
    checkOutput({pfx, "_r_data"}, 32'(r_data), 32'd0);
    checkOutput({pfx, "_l_vld"}, 32'(l_vld), 32'd0);
    checkOutput({pfx, "_r_vld"}, 32'(r_vld), 32'd0);
    checkOutput({pfx, "_frame_err"}, 32'(frame_err), 32'd0);
  endtask

  // Asserts reset (optionally checking the immediate asynchronous effect),
  // holds it across two rising edges, and releases it on a negedge.
  task automatic doReset(input bit async_chk);
    rst   = 1'b1;
    lrck  = 1'b0;
    sdata = 1'b0;
    #1;
    if (async_chk) checkZero("rst_async");
    repeat (2) @(negedge sck);
    checkZero("reset");
    rst = 1'b0;
  endtask

  initial begin
    int            base;
    int            len;
    int            sel;
    bit            ch;
    logic [DW-1:0] cross_exp;

    $display("[TB] start, FMT_DLY=%0d", FMT_DLY);

    // Two plain 16-bit frames.
    doReset(1'b0);
    newSegment();
    addIdle(1'b0, 5);
    addSlot(1'b1, 16, 16'($urandom), FMT_DLY, 1'b0);
    addSlot(1'b0, 16, 16'h8001, FMT_DLY, 1'b0);
    addSlot(1'b1, 16, 16'h7FFE, FMT_DLY, 1'b0);
    addIdle(1'b0, 3);
    applyStimulus(seg_lr.size());
    checkOutput("frame16_left", 32'(l_data), 32'h8001);
    checkOutput("frame16_right", 32'(r_data), 32'h7FFE);

    // 32-bit slots with padding (also the edge-at-timeout boundary).
    doReset(1'b0);
    newSegment();
    addIdle(1'b0, 5);
    addSlot(1'b1, 32, 16'($urandom), FMT_DLY, 1'b0);
    addSlot(1'b0, 32, 16'h1234, FMT_DLY, 1'b1);
    addSlot(1'b1, 32, 16'($urandom), FMT_DLY, 1'b0);
    addIdle(1'b0, 3);
    applyStimulus(seg_lr.size());
    checkOutput("pad32_left", 32'(l_data), 32'h1234);
    checkOutput("pad32_errs", 32'(err_pulses), 32'd0);

    // Short 12-bit slot.
    doReset(1'b0);
    newSegment();
    addIdle(1'b0, 5);
    addSlot(1'b1, 16, 16'($urandom), FMT_DLY, 1'b0);
    addSlot(1'b0, 12, 16'hABC0, FMT_DLY, 1'b0);
    addIdle(1'b1, 3);
    applyStimulus(seg_lr.size());
    checkOutput("short_left", 32'(l_data), 32'hABC0);
    checkOutput("short_errs", 32'(err_pulses), 32'd1);

    // lrck stuck for 40 cycles, then recovery.
    doReset(1'b0);
    newSegment();
    addIdle(1'b0, 5);
    addSlot(1'b1, 16, 16'($urandom), FMT_DLY, 1'b0);
    addSlot(1'b0, 40, 16'($urandom), FMT_DLY, 1'b0);
    addSlot(1'b1, 16, 16'($urandom), FMT_DLY, 1'b0);
    addSlot(1'b0, 16, 16'hC3A5, FMT_DLY, 1'b0);
    addIdle(1'b1, 3);
    applyStimulus(seg_lr.size());
    checkOutput("timeout_errs", 32'(err_pulses), 32'd1);
    checkOutput("timeout_recover", 32'(l_data), 32'hC3A5);

    // Reset asserted in the middle of a left slot.
    doReset(1'b0);
    newSegment();
    addIdle(1'b0, 5);
    addSlot(1'b1, 16, 16'($urandom), FMT_DLY, 1'b0);
    addSlot(1'b0, 16, 16'($urandom), FMT_DLY, 1'b0);
    addSlot(1'b1, 16, 16'($urandom), FMT_DLY, 1'b0);
    addSlot(1'b0, 20, 16'($urandom), FMT_DLY, 1'b0);
    applyStimulus(63);
    #2;
    doReset(1'b1);
    newSegment();
    addIdle(1'b0, 7);
    addSlot(1'b1, 16, 16'($urandom), FMT_DLY, 1'b0);
    addSlot(1'b0, 16, 16'h0F1E, FMT_DLY, 1'b0);
    addIdle(1'b1, 3);
    applyStimulus(seg_lr.size());
    checkOutput("after_reset_left", 32'(l_data), 32'h0F1E);

    // Left-justified stream: exact in LJ builds, shifted by one in Philips.
    doReset(1'b0);
    newSegment();
    addIdle(1'b0, 5);
    addSlot(1'b1, 16, 16'($urandom), FMT_DLY, 1'b0);
    base = seg_lr.size();
    addSlot(1'b0, 16, 16'h5A5A, 0, 1'b0);
    addSlot(1'b1, 16, 16'($urandom), FMT_DLY, 1'b0);
    addIdle(1'b0, 3);
`ifdef I2S_LJ_MODE_EN
    cross_exp = 16'h5A5A;
`else
    cross_exp = 16'hB4B4 | 16'(seg_sd[base + 16]);
`endif
    applyStimulus(seg_lr.size());
    checkOutput("lj_stream_left", 32'(l_data), 32'(cross_exp));

    // Randomized slot lengths and data.
    for (int s = 0; s < 4; s++) begin
      doReset(1'b0);
      newSegment();
      addIdle(1'b0, $urandom_range(1, 6));
      ch = 1'b1;
      for (int k = 0; k < 12; k++) begin
        sel = $urandom_range(0, 9);
        if (sel == 0)      len = $urandom_range(4, DW - 1);
        else if (sel == 1) len = $urandom_range(SW + 1, SW + 8);
        else               len = $urandom_range(DW, SW);
        addSlot(ch, len, 16'($urandom), FMT_DLY, 1'b0);
        ch = ~ch;
      end
      addIdle(ch, 3);
      applyStimulus(seg_lr.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
